// File: rtl/key_debounce_repeat_pkg.sv
// Repeat FSM state encoding and default timing constants for the pushbutton debouncer.
// Shared by the per-key cell and the top level.
package key_debounce_repeat_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_TICKS = 10;
    localparam int DEF_REPEAT_DELAY = 500;
    localparam int DEF_REPEAT_RATE  = 100;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One pushbutton channel: 2-flop sync, tick-sampled debounce, auto-repeat FSM, registered pulses.
// Level/pulse outputs change on the tick edge that accepts the change; no backpressure.
module key_debounce_cell
    import key_debounce_repeat_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int REPEAT_EN    = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int DB_W = $clog2(STABLE_TICKS + 1);
    localparam int RP_W = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(STABLE_TICKS - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic [RP_W-1:0] r_rep_cnt;
    rep_state_t      r_state;
    logic            r_level;
    logic            r_press;
    logic            r_release;

    logic w_sample;
    logic w_differs;
    logic w_accept;

    assign w_sample  = ~r_sync2;
    assign w_differs = i_tick & (w_sample != r_level);
    // The tick that would bring the counter to STABLE_TICKS accepts the new level instead.
    assign w_accept  = w_differs & (r_db_cnt == DB_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db_cnt  <= '0;
            r_rep_cnt <= '0;
            r_state   <= IDLE;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;

            if (i_tick) begin
                r_db_cnt <= (w_differs && !w_accept) ? r_db_cnt + 1'b1 : '0;
            end

            // An accepted level change outranks any repeat event on the same tick.
            if (w_accept) begin
                r_level   <= ~r_level;
                r_rep_cnt <= '0;
                if (r_level) begin
                    r_release <= 1'b1;
                    r_state   <= IDLE;
                end else begin
                    r_press   <= 1'b1;
                    r_state   <= (REPEAT_EN != 0) ? DELAY : IDLE;
                end
            end else if (i_tick) begin
                case (r_state)
                    DELAY: begin
                        if (r_rep_cnt == DELAY_LAST) begin
                            r_press   <= 1'b1;
                            r_rep_cnt <= '0;
                            r_state   <= REPEAT;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (r_rep_cnt == RATE_LAST) begin
                            r_press   <= 1'b1;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_rep_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/key_debounce_repeat.sv
// NUM_KEYS debounced pushbuttons with auto-repeat, sharing one sample-tick divider.
// Level change lands 2 sync cycles + STABLE_TICKS ticks after a clean edge; no backpressure.
module key_debounce_repeat
    import key_debounce_repeat_pkg::*;
#(
    parameter int NUM_KEYS     = 3,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int REPEAT_EN    = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int TK_W = max2($clog2(TICK_DIV), 1);
    localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICK_DIV - 1);

    logic [TK_W-1:0] r_tick_cnt;
    logic            w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_EN)
        ) u_cell (
            .i_clk     (CLOCK_50),
            .i_reset   (reset),
            .i_tick    (w_tick),
            .i_key_n   (KEY[g]),
            .o_level   (key_level[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench: expected pulse events (edge, key, kind) are queued when keys are driven
// and popped by a monitor each time the DUT emits a pulse.
module tb_key_debounce_repeat;

    localparam int NK = 3;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    typedef struct packed {
        int   at;
        int   key;
        logic rel;
    } ev_t;

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b1;
    logic [NK-1:0] KEY      = '1;
    logic [NK-1:0] key_level, key_press, key_release;
    logic [NK-1:0] key_nr   = '1;
    logic [NK-1:0] lvl_nr, prs_nr, rel_nr;

    int  cyc     = 0;
    int  rbase   = 0;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  nr_press = 0;
    int  nr_rel   = 0;
    ev_t exp_q[$];
    ev_t mon_a, mon_e;

    key_debounce_repeat #(
        .NUM_KEYS(NK), .TICK_DIV(TD), .STABLE_TICKS(ST),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_EN(1)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .KEY(KEY),
        .key_level(key_level), .key_press(key_press), .key_release(key_release)
    );

    key_debounce_repeat #(
        .NUM_KEYS(NK), .TICK_DIV(TD), .STABLE_TICKS(ST),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_EN(0)
    ) dut_nr (
        .CLOCK_50(CLOCK_50), .reset(reset), .KEY(key_nr),
        .key_level(lvl_nr), .key_press(prs_nr), .key_release(rel_nr)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    // Ticks fall on edges rbase + TD*m, m >= 1.
    function automatic int tick_at_or_after(input int x);
        int m;
        m = (x - rbase + TD - 1) / TD;
        if (m < 1) m = 1;
        return rbase + TD * m;
    endfunction

    // Raw edge before posedge e: synced sample is seen from e+2, level flips on the ST-th tick.
    function automatic int accept_edge(input int e);
        return tick_at_or_after(e + 2) + TD * (ST - 1);
    endfunction

    function automatic void push_exp(input int at, input int key, input logic rel);
        ev_t ev;
        int  i;
        ev = '{at: at, key: key, rel: rel};
        i = 0;
        while (i < exp_q.size() &&
               (exp_q[i].at < at || (exp_q[i].at == at && exp_q[i].key < key)))
            i++;
        exp_q.insert(i, ev);
    endfunction

    function automatic void push_hold(input int key, input int p, input int q);
        push_exp(p, key, 1'b0);
        for (int r = p + TD * RD; r < q; r += TD * RR)
            push_exp(r, key, 1'b0);
        push_exp(q, key, 1'b1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s got=%0h want=%0h cyc=%0d", tag, got, want, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge CLOCK_50);
    endtask

    task automatic press_hold(input logic [NK-1:0] mask, input int hold, input string tag);
        int e, p, q;
        e = cyc + 1;
        p = accept_edge(e);
        q = accept_edge(e + hold);
        for (int k = 0; k < NK; k++)
            if (mask[k]) push_hold(k, p, q);
        KEY = KEY & ~mask;
        wait_cyc(p);
        check({tag, "_level_up"}, 32'(key_level), 32'(mask));
        wait_cyc(e + hold - 1);
        KEY = KEY | mask;
        wait_cyc(q);
        check({tag, "_level_down"}, 32'(key_level), 32'd0);
        wait_cyc(q + 3 * TD);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge CLOCK_50) begin
        nr_press += $countones(prs_nr);
        nr_rel   += $countones(rel_nr);
        for (int k = 0; k < NK; k++) begin
            n_tests++;
            assert (!(key_press[k] === 1'b1 && key_release[k] === 1'b1)) else begin
                n_fail++;
                $error("FAIL both_pulses key=%0d cyc=%0d got press=1 release=1 want at most one", k, cyc);
            end
            if (key_press[k] === 1'b1 || key_release[k] === 1'b1) begin
                mon_a = '{at: cyc, key: k, rel: key_release[k]};
                if (exp_q.size() > 0) mon_e = exp_q.pop_front();
                else                  mon_e = '{at: -1, key: -1, rel: 1'b0};
                n_tests++;
                assert (mon_a === mon_e) else begin
                    n_fail++;
                    $error("FAIL pulse_event got(at=%0d key=%0d rel=%0b) want(at=%0d key=%0d rel=%0b)",
                           mon_a.at, mon_a.key, mon_a.rel, mon_e.at, mon_e.key, mon_e.rel);
                end
            end
        end
    end

    initial begin
        int e, p, r, p2, q2;

        repeat (3) @(negedge CLOCK_50);
        check("rst_level",   32'(key_level),   32'd0);
        check("rst_press",   32'(key_press),   32'd0);
        check("rst_release", 32'(key_release), 32'd0);
        reset = 1'b0;
        rbase = cyc;
        repeat (20) @(negedge CLOCK_50);

        press_hold(3'b001, 40, "single");

        KEY[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            check("glitch_level_low", 32'(key_level), 32'd0);
        end
        KEY[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            check("glitch_level_after", 32'(key_level), 32'd0);
        end

        press_hold(3'b001, 100, "hold");
        press_hold(3'b101, 60, "dual");

        // Reset pulse while key 0 sits in REPEAT; it re-presses after 3 ticks.
        e = cyc + 1;
        p = accept_edge(e);
        push_exp(p, 0, 1'b0);
        push_exp(p + TD * RD, 0, 1'b0);
        push_exp(p + TD * RD + TD * RR, 0, 1'b0);
        KEY[0] = 1'b0;
        wait_cyc(p + TD * RD + TD * RR + 1);
        check("rst_pre_level", 32'(key_level), 32'd1);
        wait_cyc(p + 30);
        reset = 1'b1;
        r = p + 31;
        wait_cyc(r);
        check("rst_mid_outputs", 32'({key_level, key_press, key_release}), 32'd0);
        check("rst_mid_drained", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        rbase = r;
        p2 = accept_edge(r + 1);
        q2 = accept_edge(r + 31);
        check("rst_rerise_edge", 32'(p2 - r), 32'(3 * TD));
        push_hold(0, p2, q2);
        wait_cyc(p2);
        check("rst_rerise_level", 32'(key_level), 32'd1);
        wait_cyc(r + 30);
        KEY[0] = 1'b1;
        wait_cyc(q2 + 3 * TD);
        check("rst_post_drained", 32'(exp_q.size()), 32'd0);
        check("rst_post_level", 32'(key_level), 32'd0);

        nr_press = 0;
        nr_rel   = 0;
        key_nr[0] = 1'b0;
        repeat (200) @(negedge CLOCK_50);
        check("norep_level_held", 32'(lvl_nr), 32'd1);
        check("norep_press_cnt_held", 32'(nr_press), 32'd1);
        key_nr[0] = 1'b1;
        repeat (40) @(negedge CLOCK_50);
        check("norep_press_cnt", 32'(nr_press), 32'd1);
        check("norep_release_cnt", 32'(nr_rel), 32'd1);
        check("norep_level_down", 32'(lvl_nr), 32'd0);

        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
